axis_mux_sched: RTL and testbench
=================================

Name: axis_mux_sched

Overview:
- Frame-level weighted round-robin scheduler that drives the `enable`/`sel` control inputs of the 4-port AXI-Stream mux.
- It observes input `tvalid` lines and the mux output handshake, grants one source per frame burst, and never changes `sel` mid-frame.
- It sits beside the mux in the same clock domain and replaces the static select driven from software.

Parameters:
- S_COUNT, 4, number of mux inputs (2..16).
- SEL_WIDTH, $clog2(S_COUNT), width of `sel`.
- WEIGHT_WIDTH, 4, width of per-port frame-credit weight.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tvalid  in  S_COUNT  tvalid of each mux input (observe only)
- m_axis_tvalid  in  1  mux output tvalid (observe)
- m_axis_tready  in  1  mux output tready (observe)
- m_axis_tlast  in  1  mux output tlast (observe)
- port_enable  in  S_COUNT  per-port eligibility mask
- port_weight  in  S_COUNT*WEIGHT_WIDTH  frames per grant; port i occupies bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- enable  out  1  to mux `enable`
- sel  out  SEL_WIDTH  to mux `sel`
- busy  out  1  a granted frame is in progress

Behaviour:
- Port roles: one clock; reset is synchronous and active-high on `rst`. All outputs are registered.
- Reset values: enable=0, sel=0, busy=0, state=IDLE, credit=0, rr_ptr=S_COUNT-1 (port 0 wins first), stick=0.
- Eligibility: req[i] = s_axis_tvalid[i] & port_enable[i].
- Effective weight: weight 0 is treated as 1.
- Beat: m_axis_tvalid & m_axis_tready. Frame end: beat & m_axis_tlast.
- State IDLE (enable=0):
  - No req: stay in IDLE.
  - Otherwise pick a winner.
    - If stick=1 and req[sel]=1, the winner is sel, and credit is kept.
    - Else the winner is the first req at index (rr_ptr+1) upward, wrapping modulo S_COUNT. Then credit := effective weight, and rr_ptr := winner.
  - Next cycle: sel=winner, enable=1, state=GRANT, stick cleared.
- Grant latency: 1 cycle from req visible in IDLE to enable=1.
- State GRANT (enable=1, sel frozen):
  - Beat without tlast: busy := 1.
  - Frame end: busy := 0, credit := credit-1, state := IDLE, enable := 0 next cycle.
    - stick := (credit-1 != 0).
  - Release: busy=0 and req[sel]=0 and no beat this cycle → state := IDLE, credit := 0, stick := 0.
    - This covers a source that drops valid before its first beat, and a port disabled before its first beat.
- port_enable[sel] falling while busy=1: the frame completes normally, then stick := 0 (no further credit).
- Single-beat frame (tlast on the first beat): counts as frame end; busy stays 0.
- One dead cycle (enable=0) follows every frame end. This is required so that `sel` changes only while the mux is idle.
- Sustained throughput: at most 1 bubble per frame.
- Fairness: with all ports requesting, each port gets effective-weight frames per round.
- Starvation: impossible for enabled ports.
- rst mid-frame: immediate return to reset values. The mux shares `rst` and is reset in the same cycle.
- Credit counter is WEIGHT_WIDTH bits; it never underflows because decrement happens only in GRANT with credit ≥ 1.

Decomposition:
- Package axis_mux_sched_pkg holds:
  - state enum {IDLE, GRANT}
  - function `eff_weight` (0→1)
  - function `wrap_inc` for modulo-S_COUNT pointer arithmetic
- Sub-module axis_mux_sched_rr: combinational rotating-priority find-first.
  - Inputs: req, rr_ptr.
  - Outputs: winner index, any_req.

Test Plan:
1. Reset, then s_axis_tvalid=4'b0001, weights all 1, single 3-beat frame.
   → enable=1 and sel=0 exactly 1 cycle after tvalid; busy=1 after beat 1; enable=0 the cycle after the tlast beat.
2. All 4 ports continuously valid, weights {1,1,1,1}, 2-beat frames.
   → sel sequence 0,1,2,3,0,…; exactly one enable=0 cycle between frames.
3. All valid, port_weight = {0,1,3,2} for ports {3,2,1,0}.
   → per round: port0 ×2, port1 ×3, port2 ×1, port3 ×1 (weight 0 treated as 1); sel repeats within a port's credit.
4. Grant port 2, drop s_axis_tvalid[2] before any beat.
   → GRANT exits to IDLE next cycle with credit=0; next grant goes to port 3 if requesting.
5. port_enable[1] cleared mid-frame of port 1 (weight 3).
   → frame finishes with all beats passed; next grant is not port 1; sel is unchanged until the tlast beat.
6. rst asserted while busy=1 on port 3.
   → next cycle enable=0, sel=0, busy=0; after release, with ports 0 and 3 requesting, port 0 is granted first.

Source files
------------

// File: rtl/axis_mux_sched_pkg.sv
// Shared types and helpers for the frame-level weighted round-robin mux scheduler.
package axis_mux_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_t;

   // A programmed weight of zero still earns one frame per grant.
   function automatic int unsigned eff_weight(input int unsigned w);
      return (w == 32'd0) ? 32'd1 : w;
   endfunction

   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
   endfunction

endpackage

// File: rtl/axis_mux_sched_if.sv
// Mux-side observation and control bundle between the scheduler and the 4-port AXI-Stream mux.
interface axis_mux_sched_if #(
   parameter int unsigned S_COUNT   = 4,
   parameter int unsigned SEL_WIDTH = $clog2(S_COUNT)
);
   logic [S_COUNT-1:0]   s_axis_tvalid;
   logic                 m_axis_tvalid;
   logic                 m_axis_tready;
   logic                 m_axis_tlast;
   logic                 enable;
   logic [SEL_WIDTH-1:0] sel;
   logic                 busy;

   // Scheduler side: observes the stream, drives the mux controls.
   modport master (
      input  s_axis_tvalid, m_axis_tvalid, m_axis_tready, m_axis_tlast,
      output enable, sel, busy
   );

   // Mux/stream side: provides the observed handshake, consumes the controls.
   modport slave (
      output s_axis_tvalid, m_axis_tvalid, m_axis_tready, m_axis_tlast,
      input  enable, sel, busy
   );
endinterface

// File: rtl/axis_mux_sched_rr.sv
// Rotating-priority find-first: the first requester strictly after rr_ptr, wrapping.
module axis_mux_sched_rr
   import axis_mux_sched_pkg::*;
#(
   parameter int unsigned S_COUNT   = 4,
   parameter int unsigned SEL_WIDTH = $clog2(S_COUNT)
) (
   input  logic [S_COUNT-1:0]   req,
   input  logic [SEL_WIDTH-1:0] rr_ptr,
   output logic [SEL_WIDTH-1:0] winner_c,
   output logic                 any_req_c
);

   logic [SEL_WIDTH-1:0] idx;
   logic                 found;

   always_comb begin
      winner_c  = '0;
      any_req_c = |req;
      found     = 1'b0;
      idx       = SEL_WIDTH'(wrap_inc(32'(rr_ptr), S_COUNT));
      for (int unsigned i = 0; i < S_COUNT; i++) begin
         if (!found && req[idx]) begin
            winner_c = idx;
            found    = 1'b1;
         end
         idx = SEL_WIDTH'(wrap_inc(32'(idx), S_COUNT));
      end
   end

endmodule

// File: rtl/axis_mux_sched.sv
// Frame-level weighted round-robin scheduler driving the mux enable/sel; sel only moves while the mux is idle.
module axis_mux_sched
   import axis_mux_sched_pkg::*;
#(
   parameter int unsigned S_COUNT      = 4,
   parameter int unsigned SEL_WIDTH    = $clog2(S_COUNT),
   parameter int unsigned WEIGHT_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   axis_mux_sched_if.master                bus,
   input  logic [S_COUNT-1:0]              port_enable,
   input  logic [S_COUNT*WEIGHT_WIDTH-1:0] port_weight
);

   sched_state_t            state;
   logic                    enable_r;
   logic [SEL_WIDTH-1:0]    sel_r;
   logic                    busy_r;
   logic [WEIGHT_WIDTH-1:0] credit;
   logic [SEL_WIDTH-1:0]    rr_ptr;
   logic                    stick;
   logic                    revoked;

   logic [S_COUNT-1:0]      req;
   logic                    beat;
   logic                    frame_end;
   logic [SEL_WIDTH-1:0]    winner_c;
   logic                    any_req_c;
   logic [WEIGHT_WIDTH-1:0] weight_arr [S_COUNT];

   assign req       = bus.s_axis_tvalid & port_enable;
   assign beat      = bus.m_axis_tvalid & bus.m_axis_tready;
   assign frame_end = beat & bus.m_axis_tlast;

   for (genvar g = 0; g < S_COUNT; g++) begin : g_weight
      assign weight_arr[g] = port_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   end

   axis_mux_sched_rr #(
      .S_COUNT   (S_COUNT),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr (
      .req       (req),
      .rr_ptr    (rr_ptr),
      .winner_c  (winner_c),
      .any_req_c (any_req_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         enable_r <= 1'b0;
         sel_r    <= '0;
         busy_r   <= 1'b0;
         credit   <= '0;
         rr_ptr   <= SEL_WIDTH'(S_COUNT - 1);
         stick    <= 1'b0;
         revoked  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req_c) begin
                  // A port with credit left keeps the mux as long as it is still requesting.
                  if (!(stick && req[sel_r])) begin
                     sel_r  <= winner_c;
                     credit <= WEIGHT_WIDTH'(eff_weight(32'(weight_arr[winner_c])));
                     rr_ptr <= winner_c;
                  end
                  state    <= GRANT;
                  enable_r <= 1'b1;
                  stick    <= 1'b0;
                  revoked  <= 1'b0;
               end
            end
            GRANT: begin
               if (busy_r && !port_enable[sel_r]) begin
                  revoked <= 1'b1;
               end
               if (frame_end) begin
                  busy_r   <= 1'b0;
                  credit   <= credit - WEIGHT_WIDTH'(1);
                  state    <= IDLE;
                  enable_r <= 1'b0;
                  // Disabling the port mid-frame forfeits whatever credit remains.
                  stick    <= (credit != WEIGHT_WIDTH'(1)) && !revoked && port_enable[sel_r];
               end else if (beat) begin
                  busy_r <= 1'b1;
               end else if (!busy_r && !req[sel_r]) begin
                  state    <= IDLE;
                  enable_r <= 1'b0;
                  credit   <= '0;
                  stick    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.enable = enable_r;
   assign bus.sel    = sel_r;
   assign bus.busy   = busy_r;

endmodule

// File: tb/tb_axis_mux_sched.sv
// Randomized and directed bench for axis_mux_sched with a frame-level reference scheduler and a mux/source model.
module tb_axis_mux_sched;

   localparam int S  = 4;
   localparam int WW = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [S-1:0]  port_enable;
   logic [S*WW-1:0] port_weight;

   always #5 clk = ~clk;

   axis_mux_sched_if #(.S_COUNT(S), .SEL_WIDTH(SW)) bus ();

   axis_mux_sched #(
      .S_COUNT      (S),
      .SEL_WIDTH    (SW),
      .WEIGHT_WIDTH (WW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .port_enable (port_enable),
      .port_weight (port_weight)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Source/mux environment: frames queued per port, beats left in the current frame.
   int frames[$]     = '{0, 0, 0, 0};
   int beats_left[$] = '{0, 0, 0, 0};
   int flen[$]       = '{0, 0, 0, 0};
   bit hold[$]       = '{0, 0, 0, 0};
   int rdy_pct       = 0;

   // Reference scheduler: expected outputs, last round-robin winner, frames left in grant.
   bit me, mb, mkeep, mrev;
   int ms, mlast, mleft;

   int grants[$];
   bit prev_en = 1'b0;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic bit bit_of(input logic [S-1:0] v, input int i);
      return |(v & (S'(1) << i));
   endfunction

   function automatic int next_len(input int p);
      return (flen[p] == 0) ? int'($urandom_range(4, 1)) : flen[p];
   endfunction

   function automatic int frames_total();
      int t = 0;
      for (int i = 0; i < S; i++) t += frames[i];
      return t;
   endfunction

   task automatic model_step(input logic [S-1:0] req, input bit beat, input bit fend);
      int w;
      if (rst) begin
         me = 0; ms = 0; mb = 0; mlast = S - 1; mleft = 0; mkeep = 0; mrev = 0;
      end else if (!me) begin
         if (req != '0) begin
            if (!(mkeep && bit_of(req, ms))) begin
               for (int k = 1; k <= S; k++) begin
                  if (bit_of(req, (mlast + k) % S)) begin
                     ms = (mlast + k) % S;
                     break;
                  end
               end
               w     = int'((port_weight >> (ms * WW)) & 16'hF);
               mleft = (w == 0) ? 1 : w;
               mlast = ms;
            end
            me = 1; mkeep = 0; mrev = 0;
         end
      end else begin
         if (mb && !bit_of(port_enable, ms)) mrev = 1;
         if (fend) begin
            mb = 0; mleft--; me = 0;
            mkeep = (mleft > 0) && !mrev && bit_of(port_enable, ms);
         end else if (beat) begin
            mb = 1;
         end else if (!mb && !bit_of(req, ms)) begin
            me = 0; mleft = 0; mkeep = 0;
         end
      end
   endtask

   // One clock: drive sources and the mux datapath at negedge, advance models at posedge, compare after.
   task automatic step();
      logic [S-1:0] sv;
      bit mv, rd, tl;
      int s;
      @(negedge clk);
      sv = '0;
      for (int i = 0; i < S; i++) if (frames[i] > 0 && !hold[i]) sv |= S'(1) << i;
      s  = int'(bus.sel);
      mv = (bus.enable === 1'b1) && bit_of(sv, s);
      rd = (int'($urandom_range(99)) < rdy_pct);
      tl = mv && (beats_left[s] == 1);
      bus.s_axis_tvalid = sv;
      bus.m_axis_tvalid = mv;
      bus.m_axis_tready = rd;
      bus.m_axis_tlast  = tl;
      @(posedge clk);
      model_step(sv & port_enable, mv && rd, mv && rd && tl);
      if (!rst && mv && rd) begin
         beats_left[s]--;
         if (beats_left[s] == 0) begin
            frames[s]--;
            beats_left[s] = next_len(s);
         end
      end
      #1;
      chk("enable", 32'(bus.enable), 32'(me));
      chk("sel", 32'(bus.sel), 32'(ms));
      chk("busy", 32'(bus.busy), 32'(mb));
      if (bus.enable && !prev_en) grants.push_back(int'(bus.sel));
      prev_en = bus.enable;
   endtask

   task automatic load(input int p, input int n, input int len);
      frames[p]     = n;
      flen[p]       = len;
      beats_left[p] = next_len(p);
   endtask

   task automatic reset_dut();
      rst     = 1'b1;
      rdy_pct = 0;
      for (int i = 0; i < S; i++) begin
         frames[i] = 0;
         hold[i]   = 0;
      end
      step();
      step();
      rst = 1'b0;
      grants.delete();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((frames_total() > 0 || bus.enable) && n < budget) begin
         step();
         n++;
      end
      chk("drain_frames_left", frames_total(), 0);
   endtask

   int exp3[$] = '{0, 0, 1, 1, 1, 2, 3};

   initial begin
      int n;
      rst         = 1'b1;
      port_enable = '1;
      port_weight = 16'h1111;
      bus.s_axis_tvalid = '0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b0;
      bus.m_axis_tlast  = 1'b0;

      // Reset values and a single 3-beat frame on port 0.
      reset_dut();
      chk("rst_enable", 32'(bus.enable), 0);
      chk("rst_sel", 32'(bus.sel), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      load(0, 1, 3);
      rdy_pct = 100;
      step();
      chk("t1_grant_en", 32'(bus.enable), 1);
      chk("t1_grant_sel", 32'(bus.sel), 0);
      step();
      chk("t1_busy_after_beat1", 32'(bus.busy), 1);
      step();
      step();
      chk("t1_en_after_tlast", 32'(bus.enable), 0);
      chk("t1_busy_after_tlast", 32'(bus.busy), 0);

      // Equal weights, 2-beat frames: plain rotation with one dead cycle per frame.
      reset_dut();
      for (int p = 0; p < S; p++) load(p, 10, 2);
      rdy_pct = 100;
      n = 0;
      while (grants.size() < 8 && n < 100) begin
         step();
         n++;
      end
      chk("t2_grants", grants.size(), 8);
      chk("t2_cycles", n, 22);
      for (int i = 0; i < 8; i++) chk("t2_seq", grants[i], i % 4);

      // Weights {3:0, 2:1, 1:3, 0:2}: two full rounds of 0,0,1,1,1,2,3.
      reset_dut();
      port_weight = 16'h0132;
      for (int p = 0; p < S; p++) load(p, 10, 2);
      rdy_pct = 100;
      n = 0;
      while (grants.size() < 14 && n < 200) begin
         step();
         n++;
      end
      chk("t3_grants", grants.size(), 14);
      for (int i = 0; i < 14; i++) chk("t3_seq", grants[i], exp3[i % 7]);

      // Granted source drops valid before its first beat.
      reset_dut();
      port_weight = 16'h1111;
      load(2, 1, 2);
      load(3, 1, 2);
      step();
      chk("t4_grant_sel", 32'(bus.sel), 2);
      chk("t4_grant_en", 32'(bus.enable), 1);
      hold[2] = 1;
      step();
      chk("t4_release_en", 32'(bus.enable), 0);
      rdy_pct = 100;
      step();
      chk("t4_next_sel", 32'(bus.sel), 3);
      chk("t4_next_en", 32'(bus.enable), 1);
      hold[2] = 0;
      drain(100);

      // Port 1 (weight 3) disabled mid-frame: frame completes, credit forfeited.
      reset_dut();
      port_weight = 16'h1131;
      load(1, 5, 4);
      load(2, 2, 2);
      rdy_pct = 100;
      step();
      chk("t5_grant_sel", 32'(bus.sel), 1);
      step();
      chk("t5_busy", 32'(bus.busy), 1);
      port_enable = 4'b1101;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t5_sel_hold", 32'(bus.sel), 1);
         chk("t5_en_hold", 32'(bus.enable), 1);
      end
      step();
      chk("t5_en_after_tlast", 32'(bus.enable), 0);
      chk("t5_frames_port1", frames[1], 4);
      step();
      chk("t5_next_sel", 32'(bus.sel), 2);
      chk("t5_next_en", 32'(bus.enable), 1);
      port_enable = '1;
      drain(300);

      // Reset while port 3 is mid-frame; port 0 wins afterwards.
      reset_dut();
      port_weight = 16'h1111;
      load(3, 2, 4);
      rdy_pct = 100;
      step();
      chk("t6_grant_sel", 32'(bus.sel), 3);
      step();
      chk("t6_busy", 32'(bus.busy), 1);
      rst     = 1'b1;
      rdy_pct = 0;
      step();
      chk("t6_rst_enable", 32'(bus.enable), 0);
      chk("t6_rst_sel", 32'(bus.sel), 0);
      chk("t6_rst_busy", 32'(bus.busy), 0);
      rst = 1'b0;
      load(0, 1, 2);
      rdy_pct = 100;
      step();
      chk("t6_first_sel", 32'(bus.sel), 0);
      chk("t6_first_en", 32'(bus.enable), 1);
      drain(200);

      // Random weights, masks, backpressure, valid drops and enable toggles.
      for (int r = 0; r < 8; r++) begin
         reset_dut();
         port_weight = 16'($urandom);
         port_enable = S'($urandom);
         rdy_pct     = int'($urandom_range(100, 30));
         for (int p = 0; p < S; p++) load(p, int'($urandom_range(8)), 0);
         for (int c = 0; c < 250; c++) begin
            if ($urandom_range(99) < 5) port_enable ^= S'(1) << $urandom_range(S - 1);
            if ($urandom_range(99) < 3) begin
               n = int'($urandom_range(S - 1));
               hold[n] = !hold[n];
            end
            if (frames_total() == 0) load(int'($urandom_range(S - 1)), int'($urandom_range(6, 1)), 0);
            step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
